// File: rtl/clk_div_ctrl.sv
// Programmable glitch-free clock divider with valid/ready reconfiguration.
// Ratio/enable changes are deferred to a falling edge of div_clk so consumers never see runt pulses.
module clk_div_ctrl #(
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned DEFAULT_HALF = 4,
  parameter bit          RESET_RUN    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_half,
  input  logic             cfg_enable,
  output logic             div_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             running,
  output logic [DIV_W-1:0] cur_half
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] RST_HALF  = (DEFAULT_HALF == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_HALF);
  localparam state_t           RST_STATE = RESET_RUN ? ST_RUN : ST_STOP;

  // A zero half-period would never toggle; treat it as 1.
  function automatic logic [DIV_W-1:0] clamp_half(input logic [DIV_W-1:0] h);
    return (h == '0) ? DIV_W'(1) : h;
  endfunction

  state_t           state, state_n;
  logic [DIV_W-1:0] count, count_n;
  logic [DIV_W-1:0] half_n;
  logic [DIV_W-1:0] sh_half, sh_half_n;
  logic             sh_enable, sh_enable_n;
  logic             div_n, rise_n, fall_n;
  logic             accept_c, last_c;

  assign accept_c = cfg_valid && cfg_ready;
  assign last_c   = (count == (cur_half - DIV_W'(1)));

  // Next-state, counter and shadow-config logic
  always_comb begin
    state_n     = state;
    count_n     = count;
    div_n       = div_clk;
    rise_n      = 1'b0;
    fall_n      = 1'b0;
    half_n      = cur_half;
    sh_half_n   = sh_half;
    sh_enable_n = sh_enable;

    case (state)
      ST_STOP: begin
        count_n = '0;
        div_n   = 1'b0;
        if (accept_c) begin
          half_n = clamp_half(cfg_half);
          if (cfg_enable) begin
            state_n = ST_RUN;
          end
        end
      end

      ST_RUN, ST_PEND: begin
        if (last_c) begin
          count_n = '0;
          div_n   = ~div_clk;
          rise_n  = ~div_clk;
          fall_n  = div_clk;
        end else begin
          count_n = count + DIV_W'(1);
        end

        if (state == ST_RUN) begin
          if (accept_c) begin
            sh_half_n   = cfg_half;
            sh_enable_n = cfg_enable;
            state_n     = ST_PEND;
          end
        end else if (last_c && div_clk) begin
          // Shadowed config lands only on a falling toggle, after a full high phase
          half_n  = clamp_half(sh_half);
          state_n = sh_enable ? ST_RUN : ST_STOP;
        end
      end

      default: begin
        state_n = ST_STOP;
        count_n = '0;
        div_n   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RST_STATE;
      count      <= '0;
      div_clk    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      cur_half   <= RST_HALF;
      sh_half    <= '0;
      sh_enable  <= 1'b0;
      cfg_ready  <= 1'b1;
      running    <= RESET_RUN;
    end else begin
      state      <= state_n;
      count      <= count_n;
      div_clk    <= div_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
      cur_half   <= half_n;
      sh_half    <= sh_half_n;
      sh_enable  <= sh_enable_n;
      cfg_ready  <= (state_n != ST_PEND);
      running    <= (state_n != ST_STOP);
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: vector table for the reset/re-ratio waveform,
// hand-written sequences for stop, zero half, toggle-cycle config, reset in PEND and max half.
module tb_clk_div_ctrl;

  localparam int unsigned DIV_W = 8;

  logic             clk;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_enable;
  logic             div_clk;
  logic             rise_pulse;
  logic             fall_pulse;
  logic             running;
  logic [DIV_W-1:0] cur_half;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_ctrl #(
    .DIV_W        (DIV_W),
    .DEFAULT_HALF (4),
    .RESET_RUN    (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_half   (cfg_half),
    .cfg_enable (cfg_enable),
    .div_clk    (div_clk),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .running    (running),
    .cur_half   (cur_half)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] h;
    logic       e;
    logic       d;
    logic       r;
    logic       f;
    logic       run;
    logic       rdy;
    logic [7:0] half;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic v, input logic [7:0] h, input logic e,
                     input logic d, input logic r, input logic f, input logic run,
                     input logic rdy, input logic [7:0] half);
    vec_t t;
    t.rst = rst; t.v = v; t.h = h; t.e = e;
    t.d = d; t.r = r; t.f = f; t.run = run; t.rdy = rdy; t.half = half;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic d, input logic r, input logic f,
                         input logic run, input logic rdy, input logic [7:0] half);
    chk({tag, ".div_clk"},    32'(div_clk),    32'(d));
    chk({tag, ".rise_pulse"}, 32'(rise_pulse), 32'(r));
    chk({tag, ".fall_pulse"}, 32'(fall_pulse), 32'(f));
    chk({tag, ".running"},    32'(running),    32'(run));
    chk({tag, ".cfg_ready"},  32'(cfg_ready),  32'(rdy));
    chk({tag, ".cur_half"},   32'(cur_half),   32'(half));
  endtask

  // Drive inputs for one cycle, then sample just after the rising edge.
  task automatic cyc(input logic rst, input logic v, input logic [7:0] h, input logic e);
    reset      = rst;
    cfg_valid  = v;
    cfg_half   = h;
    cfg_enable = e;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic rst, input logic v, input logic [7:0] h,
                      input logic e, input logic d, input logic r, input logic f,
                      input logic run, input logic rdy, input logic [7:0] half);
    cyc(rst, v, h, e);
    chk_out(tag, d, r, f, run, rdy, half);
  endtask

  initial begin
    int  n;
    bit  seen;

    reset = 1'b1; cfg_valid = 1'b0; cfg_half = '0; cfg_enable = 1'b0;

    // Reset, free run at half=4, then re-ratio to 2 during a high phase
    add(1, 0, 0, 0,  0, 0, 0, 1, 1, 4);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0,  0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0,  1, 1, 0, 1, 1, 4);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0,  1, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0,  0, 0, 1, 1, 1, 4);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0,  0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0,  1, 1, 0, 1, 1, 4);
    add(0, 1, 2, 1,  1, 0, 0, 1, 0, 4);
    add(0, 1, 7, 0,  1, 0, 0, 1, 0, 4);
    add(0, 1, 7, 0,  1, 0, 0, 1, 0, 4);
    add(0, 0, 0, 0,  0, 0, 1, 1, 1, 2);
    add(0, 0, 0, 0,  0, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0,  1, 1, 0, 1, 1, 2);
    add(0, 0, 0, 0,  1, 0, 0, 1, 1, 2);
    add(0, 0, 0, 0,  0, 0, 1, 1, 1, 2);

    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].v, vq[i].h, vq[i].e);
      chk_out($sformatf("vec%0d", i), vq[i].d, vq[i].r, vq[i].f, vq[i].run, vq[i].rdy, vq[i].half);
    end

    // Stop one cycle after a rise: high phase completes, then silence
    step("stop_a", 0, 0, 0, 0,  0, 0, 0, 1, 1, 2);
    step("stop_b", 0, 0, 0, 0,  1, 1, 0, 1, 1, 2);
    step("stop_c", 0, 1, 2, 0,  1, 0, 0, 1, 0, 2);
    step("stop_d", 0, 0, 0, 0,  0, 0, 1, 0, 1, 2);
    for (int i = 0; i < 6; i++) step($sformatf("stop_idle%0d", i), 0, 0, 0, 0,  0, 0, 0, 0, 1, 2);

    // Disabled config in STOP updates only the ratio
    step("stop_cfg", 0, 1, 5, 0,  0, 0, 0, 0, 1, 5);

    // Half 0 from STOP behaves as half 1
    step("h0_a", 0, 1, 0, 1,  0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) step($sformatf("h0_r%0d", i), 0, 0, 0, 0,  1, 1, 0, 1, 1, 1);
      else            step($sformatf("h0_f%0d", i), 0, 0, 0, 0,  0, 0, 1, 1, 1, 1);
    end

    // Stop accepted on a falling toggle at half 1: waits one more full cycle
    step("h1_g", 0, 1, 3, 0,  0, 0, 1, 1, 0, 1);
    step("h1_h", 0, 0, 0, 0,  1, 1, 0, 1, 0, 1);
    step("h1_i", 0, 0, 0, 0,  0, 0, 1, 0, 1, 3);
    step("h1_j", 0, 0, 0, 0,  0, 0, 0, 0, 1, 3);

    // Half 3 run; config in the exact falling-toggle cycle applies one period later
    step("h3_k", 0, 1, 3, 1,  0, 0, 0, 1, 1, 3);
    step("h3_l", 0, 0, 0, 0,  0, 0, 0, 1, 1, 3);
    step("h3_m", 0, 0, 0, 0,  0, 0, 0, 1, 1, 3);
    step("h3_n", 0, 0, 0, 0,  1, 1, 0, 1, 1, 3);
    step("h3_o", 0, 0, 0, 0,  1, 0, 0, 1, 1, 3);
    step("h3_p", 0, 0, 0, 0,  1, 0, 0, 1, 1, 3);
    step("h3_q", 0, 1, 1, 1,  0, 0, 1, 1, 0, 3);
    step("h3_r", 0, 0, 0, 0,  0, 0, 0, 1, 0, 3);
    step("h3_s", 0, 0, 0, 0,  0, 0, 0, 1, 0, 3);
    step("h3_t", 0, 0, 0, 0,  1, 1, 0, 1, 0, 3);
    step("h3_u", 0, 0, 0, 0,  1, 0, 0, 1, 0, 3);
    step("h3_v", 0, 0, 0, 0,  1, 0, 0, 1, 0, 3);
    step("h3_w", 0, 0, 0, 0,  0, 0, 1, 1, 1, 1);
    step("h3_x", 0, 0, 0, 0,  1, 1, 0, 1, 1, 1);
    step("h3_y", 0, 0, 0, 0,  0, 0, 1, 1, 1, 1);

    // Reset while PEND with div_clk high discards the shadowed config
    step("rp_z",   0, 1, 9, 1,  1, 1, 0, 1, 0, 1);
    step("rp_rst", 1, 0, 0, 0,  0, 0, 0, 1, 1, 4);
    for (int i = 0; i < 3; i++) step($sformatf("rp_lo%0d", i), 0, 0, 0, 0,  0, 0, 0, 1, 1, 4);
    step("rp_rise", 0, 0, 0, 0,  1, 1, 0, 1, 1, 4);
    for (int i = 0; i < 3; i++) step($sformatf("rp_hi%0d", i), 0, 0, 0, 0,  1, 0, 0, 1, 1, 4);
    step("rp_fall", 0, 0, 0, 0,  0, 0, 1, 1, 1, 4);

    // Maximum half-period: counter must reach 254 without wrapping
    step("max_req", 0, 1, 8'hFF, 1,  0, 0, 0, 1, 0, 4);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(0, 0, 0, 0);
      seen = fall_pulse;
    end
    chk("max_fall_seen", 32'(seen), 32'd1);
    chk("max_cur_half", 32'(cur_half), 32'd255);
    chk("max_ready", 32'(cfg_ready), 32'd1);

    n = 0; seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      cyc(0, 0, 0, 0);
      n++;
      seen = rise_pulse;
    end
    chk("max_low_len", 32'(n), 32'd255);

    n = 0; seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      cyc(0, 0, 0, 0);
      n++;
      seen = fall_pulse;
    end
    chk("max_high_len", 32'(n), 32'd255);
    chk("max_running", 32'(running), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable, glitch-free divided-clock generator and controller for the low-speed clock domain in the CPU_stuff subsystem. It produces a 50%-duty divided clock plus one-cycle edge strobes for downstream logic. Software or the top-level FSM can start, stop or re-ratio it through a valid/ready config port. Ratio and enable changes take effect only at a falling-edge boundary of the divided clock, so no runt pulses reach consumers.

Parameters:
DIV_W, 8, width of the half-period count field
DEFAULT_HALF, 4, half-period in clk cycles after reset (4 gives the legacy divide-by-8 waveform)
RESET_RUN, 1, 1 = divider runs out of reset; 0 = stopped out of reset

Ports:
clk  input  1  system clock; sole clock
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  config request
cfg_ready  output  1  config port can accept
cfg_half  input  DIV_W  requested half-period in cycles; 0 is treated as 1
cfg_enable  input  1  1 = run, 0 = stop
div_clk  output  1  divided clock (register output)
rise_pulse  output  1  high for the one cycle in which div_clk first reads 1
fall_pulse  output  1  high for the one cycle in which div_clk first reads 0 after a high phase
running  output  1  1 when the state is RUN or PEND
cur_half  output  DIV_W  half-period currently in effect

Behaviour:
- Synchronous active-high reset; everything is sampled on posedge clk.
- State machine states: STOP, RUN, PEND (RUN with a shadowed config waiting).
- Reset values:
  - State = RUN if RESET_RUN=1, else STOP.
  - cur_half = DEFAULT_HALF; counter = 0.
  - div_clk = 0; rise_pulse = 0; fall_pulse = 0.
  - cfg_ready = 1; shadow registers = 0.
- Handshake: a config transfer occurs in any cycle where cfg_valid=1 and cfg_ready=1. cfg_ready=0 only in PEND.
- STOP:
  - div_clk is held 0 and the counter is held at 0.
  - Accepted cfg with enable=1: cur_half <= max(cfg_half,1), counter <= 0, next state RUN.
  - Accepted cfg with enable=0: only cur_half is updated; state stays STOP.
- RUN:
  - Each cycle, if counter == cur_half-1: counter <= 0, div_clk toggles, and the matching pulse is set for the next cycle. Otherwise counter increments.
  - Period is 2*cur_half cycles with 50% duty.
  - After STOP->RUN in cycle T, the first rise is visible at cycle T+1+cur_half, i.e. div_clk reads 1 starting cur_half cycles after the first RUN cycle.
- Accepted cfg in RUN: cfg_half and cfg_enable are captured into the shadow registers; next state PEND.
- Config accepted in the same cycle as a falling toggle is NOT applied at that toggle; it waits for the next falling toggle.
- PEND: counting continues exactly as in RUN. At the falling toggle (counter == cur_half-1 and div_clk==1):
  - div_clk <= 0, fall_pulse is set, counter <= 0, cur_half <= max(shadow_half,1).
  - Next state is RUN if shadow_enable=1, else STOP.
  - cfg_ready returns to 1 in the next cycle.
- The high phase is always completed: stopping never truncates a high phase, and re-ratioing never alters a phase already in progress.
- rise_pulse and fall_pulse are registered, mutually exclusive, one cycle wide, and aligned with the cycle div_clk first shows its new value.
- cur_half = 1 gives div_clk = clk/2, toggling every cycle; pulses then alternate every cycle.
- cur_half = 2^DIV_W-1 must count correctly with no overflow; the counter is DIV_W bits wide.
- Reset asserted mid-operation (RUN or PEND) discards any pending config and forces the reset values in the next cycle, regardless of div_clk phase.

Test Plan:
- Reset with RESET_RUN=1, DEFAULT_HALF=4, then release -> div_clk low 4 cycles, high 4 cycles, repeating. rise_pulse and fall_pulse are each 1 cycle wide and 4 cycles apart. cur_half=4, running=1.
- While running at half=4, send cfg_half=2, enable=1 during the high phase -> cfg_ready=0 until the falling toggle. The current high phase still lasts 4 cycles, after which the period is 4 (2 low/2 high). cfg_ready=1 the cycle after the toggle.
- While running, send enable=0 one cycle after a rise -> the high phase completes its full length, div_clk then stays 0, running=0 from the cycle after the falling toggle, no further pulses.
- From STOP, send cfg_half=0, enable=1 -> treated as half=1: cur_half=1, div_clk toggles every cycle, rise_pulse and fall_pulse alternate.
- Assert cfg_valid in exactly the cycle of a falling toggle with half=3 -> the new value is captured, the current low phase stays 3 cycles, and the new ratio applies at the following falling toggle.
- Assert reset while in PEND with div_clk=1 -> next cycle div_clk=0, cur_half=DEFAULT_HALF, cfg_ready=1, and the shadow config is lost (never applied).
